rv_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit.
- Consumes the two register-file read operands (rs1/rs2 data) plus the destination index.
- Produces a single-cycle write-back pulse that drives the register-file write port (address, data, enable) directly.
- Sits between operand read and write-back; the core stalls on `busy`.

---
 rtl/rv_pkg.sv | 38 +++
 rtl/rv_muldiv_unit_if.sv | 27 ++
 rtl/rv_muldiv_step.sv | 35 +++
 rtl/rv_muldiv_unit.sv | 135 +++++++++++++
 tb/tb_rv_muldiv_unit.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// operand width, funct3 encodings, FSM states and special-case results.
package rv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [2:0] MUL_OP    = 3'd0;
    localparam logic [2:0] MULH_OP   = 3'd1;
    localparam logic [2:0] MULHSU_OP = 3'd2;
    localparam logic [2:0] MULHU_OP  = 3'd3;
    localparam logic [2:0] DIV_OP    = 3'd4;
    localparam logic [2:0] DIVU_OP   = 3'd5;
    localparam logic [2:0] REM_OP    = 3'd6;
    localparam logic [2:0] REMU_OP   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] DIV0_Q  = '1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic rs1_is_signed(input logic [2:0] op);
        return (op == MULH_OP) || (op == MULHSU_OP) || (op == DIV_OP) || (op == REM_OP);
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] op);
        return (op == MULH_OP) || (op == DIV_OP) || (op == REM_OP);
    endfunction

endpackage

// File: rtl/rv_muldiv_unit_if.sv
// Operand-in / write-back-out bundle between the core pipeline (master)
// and the multiply/divide unit (slave).
interface rv_muldiv_unit_if;

    logic                     start;
    logic [2:0]               op;
    logic [rv_pkg::XLEN-1:0]  rs1_data;
    logic [rv_pkg::XLEN-1:0]  rs2_data;
    logic [4:0]               rd_addr;
    logic                     kill;
    logic                     ready;
    logic                     busy;
    logic                     reg_enable_write;
    logic [4:0]               reg_addr_write;
    logic [rv_pkg::XLEN-1:0]  reg_data_write;

    modport master (
        output start, op, rs1_data, rs2_data, rd_addr, kill,
        input  ready, busy, reg_enable_write, reg_addr_write, reg_data_write
    );

    modport slave (
        input  start, op, rs1_data, rs2_data, rd_addr, kill,
        output ready, busy, reg_enable_write, reg_addr_write, reg_data_write
    );

endinterface

// File: rtl/rv_muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step
// on the {acc, lo} register pair.
module rv_muldiv_step
    import rv_pkg::*;
(
    input  logic            is_div_i,
    input  logic [XLEN:0]   acc_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN:0]   acc_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;
    logic            fits;

    // NOTE: every signal written here is assigned on every path through the
    // block, so no latch can be inferred.
    always_comb begin
        sum     = acc_i + {1'b0, b_i & {XLEN{lo_i[0]}}};
        shifted = {acc_i[XLEN-1:0], lo_i[XLEN-1]};
        diff    = {1'b0, shifted} - {2'b00, b_i};
        fits    = ~diff[XLEN+1];
        if (is_div_i) begin
            acc_o = fits ? diff[XLEN:0] : shifted;
            lo_o  = {lo_i[XLEN-2:0], fits};
        end else begin
            acc_o = {1'b0, sum[XLEN:1]};
            lo_o  = {sum[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/rv_muldiv_unit.sv
// RV32M iterative multiply/divide unit: IDLE/CALC/DONE control, operand
// sign handling, special division results and registered write-back.
module rv_muldiv_unit
    import rv_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    rv_muldiv_unit_if.slave    mdu
);

    state_e           st_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       op_q;
    logic [4:0]       rd_q;
    logic             neg_q;
    logic [XLEN:0]    acc_q, acc_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  b_q;
    logic [XLEN-1:0]  result_q, result_d;
    logic             we_q;
    logic [4:0]       waddr_q;
    logic [XLEN-1:0]  wdata_q;

    logic             accept, sa, sb, div0, ovf, special;
    logic [XLEN-1:0]  mag_a, mag_b, special_res;
    logic [2*XLEN-1:0] prod;

    assign accept  = (st_q == ST_IDLE) && mdu.start && !mdu.kill;
    assign sa      = rs1_is_signed(mdu.op) && mdu.rs1_data[XLEN-1];
    assign sb      = rs2_is_signed(mdu.op) && mdu.rs2_data[XLEN-1];
    assign mag_a   = sa ? -mdu.rs1_data : mdu.rs1_data;
    assign mag_b   = sb ? -mdu.rs2_data : mdu.rs2_data;
    assign div0    = op_is_div(mdu.op) && (mdu.rs2_data == '0);
    assign ovf     = ((mdu.op == DIV_OP) || (mdu.op == REM_OP)) &&
                     (mdu.rs1_data == INT_MIN) && (mdu.rs2_data == '1);
    assign special = div0 || ovf;

    always_comb begin
        if (div0)
            special_res = ((mdu.op == DIV_OP) || (mdu.op == DIVU_OP)) ? DIV0_Q : mdu.rs1_data;
        else
            special_res = (mdu.op == DIV_OP) ? INT_MIN : '0;
    end

    rv_muldiv_step u_step (
        .is_div_i (op_is_div(op_q)),
        .acc_i    (acc_q),
        .lo_i     (lo_q),
        .b_i      (b_q),
        .acc_o    (acc_d),
        .lo_o     (lo_d)
    );

    // Sign fix-up on the final iteration's outputs, captured on entry to DONE.
    always_comb begin
        prod = {acc_d[XLEN-1:0], lo_d};
        if (neg_q)
            prod = -prod;
        case (op_q)
            MUL_OP:                       result_d = prod[XLEN-1:0];
            MULH_OP, MULHSU_OP, MULHU_OP: result_d = prod[2*XLEN-1:XLEN];
            DIV_OP, DIVU_OP:              result_d = neg_q ? -lo_d : lo_d;
            default:                      result_d = neg_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q     <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            result_q <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            we_q <= 1'b0;
            case (st_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q  <= mdu.op;
                        rd_q  <= mdu.rd_addr;
                        neg_q <= (mdu.op == REM_OP) ? sa : (sa ^ sb);
                        acc_q <= '0;
                        lo_q  <= mag_a;
                        b_q   <= mag_b;
                        cnt_q <= '0;
                        if (special) begin
                            result_q <= special_res;
                            st_q     <= ST_DONE;
                        end else begin
                            st_q     <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (mdu.kill) begin
                        st_q <= ST_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        lo_q  <= lo_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(XLEN - 1)) begin
                            result_q <= result_d;
                            st_q     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    st_q <= ST_IDLE;
                    if (!mdu.kill) begin
                        we_q    <= (rd_q != 5'd0);
                        waddr_q <= rd_q;
                        wdata_q <= result_q;
                    end
                end
                default: st_q <= ST_IDLE;
            endcase
        end
    end

    assign mdu.ready            = (st_q == ST_IDLE);
    assign mdu.busy             = (st_q != ST_IDLE);
    assign mdu.reg_enable_write = we_q;
    assign mdu.reg_addr_write   = waddr_q;
    assign mdu.reg_data_write   = wdata_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Self-checking bench for rv_muldiv_unit: directed RV32M cases, special
// division results, kill/reset/rd=0 handling and randomized ops vs a model.
module tb_rv_muldiv_unit;
    import rv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    rv_muldiv_unit_if mdu();

    rv_muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .mdu (mdu)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    // Reference model: RV32M results from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ua = longint'({32'd0, a});
        longint      ub = longint'({32'd0, b});
        int          ia = int'(a);
        int          ib = int'(b);
        logic [63:0] p;
        bit          ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            MUL_OP:    begin p = 64'(ua * ub); return p[31:0];  end
            MULH_OP:   begin p = 64'(sa * sb); return p[63:32]; end
            MULHSU_OP: begin p = 64'(sa * ub); return p[63:32]; end
            MULHU_OP:  begin p = 64'(ua * ub); return p[63:32]; end
            DIV_OP:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            DIVU_OP:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM_OP:    return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit ref_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && ((b == 0) ||
               (((op == DIV_OP) || (op == REM_OP)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_ready();
        int guard = 0;
        while (!mdu.ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!mdu.ready) begin
            n_total++;
            $display("FAIL ready_timeout: ready=%b want 1", mdu.ready);
        end
    endtask

    // Issue one op and observe max_cycles samples (#1 after each edge, k=0 is
    // just after the accept edge). Optional kill / ignored restart at sample k.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int kill_at, input int restart_at,
                         input int max_cycles, input bit stop_on_strobe,
                         output int strobe_cyc, output int strobe_cnt, output logic [31:0] data,
                         output logic [4:0] addr, output int busy_cnt, output int bad_decode);
        wait_ready();
        mdu.op = op; mdu.rs1_data = a; mdu.rs2_data = b; mdu.rd_addr = rd;
        mdu.kill = 1'b0; mdu.start = 1'b1;
        @(posedge clk); #1;
        mdu.start = 1'b0;
        mdu.rs1_data = $urandom; mdu.rs2_data = $urandom; mdu.rd_addr = 5'($urandom);
        strobe_cyc = -1; strobe_cnt = 0; busy_cnt = 0; bad_decode = 0; data = '0; addr = '0;
        for (int k = 0; k < max_cycles; k++) begin
            mdu.kill  = (k == kill_at);
            mdu.start = (k == restart_at);
            if (k == restart_at) begin
                mdu.op = ~op; mdu.rs1_data = $urandom; mdu.rs2_data = $urandom; mdu.rd_addr = ~rd;
            end
            if (mdu.busy) busy_cnt++;
            if (mdu.ready == mdu.busy) bad_decode++;
            if (mdu.reg_enable_write) begin
                if (strobe_cnt == 0) begin
                    strobe_cyc = k; data = mdu.reg_data_write; addr = mdu.reg_addr_write;
                end
                strobe_cnt++;
            end
            if (stop_on_strobe && strobe_cnt > 0) break;
            @(posedge clk); #1;
        end
        mdu.kill = 1'b0; mdu.start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (mdu.ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", mdu.ready); else n_pass++;
        n_total++; if (mdu.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", mdu.busy); else n_pass++;
        n_total++; if (mdu.reg_enable_write !== 1'b0) $display("FAIL reset_we: got %b want 0", mdu.reg_enable_write); else n_pass++;
        n_total++; if (mdu.reg_addr_write !== 5'd0) $display("FAIL reset_addr: got %0d want 0", mdu.reg_addr_write); else n_pass++;
        n_total++; if (mdu.reg_data_write !== 32'd0) $display("FAIL reset_data: got %h want 0", mdu.reg_data_write); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul_basic();
        int cyc, cnt, busy, bad;
        logic [31:0] data;
        logic [4:0]  addr;
        issue(MUL_OP, 32'd7, 32'd6, 5'd5, -1, 5, 40, 1'b0, cyc, cnt, data, addr, busy, bad);
        n_total++; if (cyc !== 33) $display("FAIL mul_latency: got %0d want 33", cyc); else n_pass++;
        n_total++; if (data !== 32'h0000_002A) $display("FAIL mul_data: got %h want 0000002a", data); else n_pass++;
        n_total++; if (addr !== 5'd5) $display("FAIL mul_addr: got %0d want 5", addr); else n_pass++;
        n_total++; if (cnt !== 1) $display("FAIL mul_strobe_count: got %0d want 1", cnt); else n_pass++;
        n_total++; if (busy !== 33) $display("FAIL mul_busy_window: got %0d want 33", busy); else n_pass++;
        n_total++; if (bad !== 0) $display("FAIL mul_ready_busy_decode: got %0d bad samples want 0", bad); else n_pass++;
    endtask

    task automatic test_directed();
        vec_t v[14];
        int cyc, cnt, busy, bad, lat;
        logic [31:0] data;
        logic [4:0]  addr;
        v[0]  = '{MULH_OP,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        v[1]  = '{MULHU_OP,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
        v[2]  = '{MULHSU_OP, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
        v[3]  = '{DIV_OP,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
        v[4]  = '{REM_OP,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
        v[5]  = '{DIVU_OP,   32'd100,       32'd7,         32'd14,        1'b0};
        v[6]  = '{REMU_OP,   32'd100,       32'd7,         32'd2,         1'b0};
        v[7]  = '{DIV_OP,    32'h1234_5678, 32'h0,         32'hFFFF_FFFF, 1'b1};
        v[8]  = '{REMU_OP,   32'h1234_5678, 32'h0,         32'h1234_5678, 1'b1};
        v[9]  = '{DIV_OP,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        v[10] = '{REM_OP,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        v[11] = '{REM_OP,    32'h8000_0000, 32'h0,         32'h8000_0000, 1'b1};
        v[12] = '{DIVU_OP,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        v[13] = '{MUL_OP,    32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFD6, 1'b0};
        for (int i = 0; i < 14; i++) begin
            lat = v[i].special ? 1 : 33;
            issue(v[i].op, v[i].a, v[i].b, 5'(i + 1), -1, -1, 40, 1'b0, cyc, cnt, data, addr, busy, bad);
            n_total++; if (data !== v[i].exp) $display("FAIL dir%0d_data: got %h want %h", i, data, v[i].exp); else n_pass++;
            n_total++; if (addr !== 5'(i + 1)) $display("FAIL dir%0d_addr: got %0d want %0d", i, addr, i + 1); else n_pass++;
            n_total++; if (cyc !== lat) $display("FAIL dir%0d_latency: got %0d want %0d", i, cyc, lat); else n_pass++;
            n_total++; if (cnt !== 1) $display("FAIL dir%0d_strobe_count: got %0d want 1", i, cnt); else n_pass++;
            n_total++; if (busy !== lat) $display("FAIL dir%0d_busy_window: got %0d want %0d", i, busy, lat); else n_pass++;
        end
    endtask

    task automatic test_kill();
        int cyc, cnt, busy, bad;
        logic [31:0] data;
        logic [4:0]  addr;
        issue(MUL_OP, 32'h1234, 32'h55, 5'd7, 20, -1, 22, 1'b0, cyc, cnt, data, addr, busy, bad);
        n_total++; if (cnt !== 0) $display("FAIL kill_calc_strobe: got %0d strobes want 0", cnt); else n_pass++;
        n_total++; if (busy !== 21) $display("FAIL kill_calc_busy: got %0d want 21", busy); else n_pass++;
        n_total++; if (mdu.ready !== 1'b1) $display("FAIL kill_calc_ready: got %b want 1", mdu.ready); else n_pass++;
        issue(DIVU_OP, 32'd1000, 32'd3, 5'd8, -1, -1, 40, 1'b0, cyc, cnt, data, addr, busy, bad);
        n_total++; if (data !== 32'd333) $display("FAIL kill_restart_data: got %h want %h", data, 32'd333); else n_pass++;
        n_total++; if (cyc !== 33) $display("FAIL kill_restart_latency: got %0d want 33", cyc); else n_pass++;
        issue(MULHU_OP, 32'hFFFF_0000, 32'h0001_0000, 5'd9, 32, -1, 40, 1'b0, cyc, cnt, data, addr, busy, bad);
        n_total++; if (cnt !== 0) $display("FAIL kill_done_strobe: got %0d strobes want 0", cnt); else n_pass++;
        n_total++; if (busy !== 33) $display("FAIL kill_done_busy: got %0d want 33", busy); else n_pass++;
    endtask

    task automatic test_kill_start_idle();
        int strobes = 0;
        wait_ready();
        mdu.op = MUL_OP; mdu.rs1_data = 32'd3; mdu.rs2_data = 32'd4; mdu.rd_addr = 5'd3;
        mdu.start = 1'b1; mdu.kill = 1'b1;
        @(posedge clk); #1;
        mdu.start = 1'b0; mdu.kill = 1'b0;
        n_total++; if (mdu.busy !== 1'b0) $display("FAIL kill_idle_busy: got %b want 0", mdu.busy); else n_pass++;
        n_total++; if (mdu.ready !== 1'b1) $display("FAIL kill_idle_ready: got %b want 1", mdu.ready); else n_pass++;
        for (int k = 0; k < 40; k++) begin
            if (mdu.reg_enable_write) strobes++;
            @(posedge clk); #1;
        end
        n_total++; if (strobes !== 0) $display("FAIL kill_idle_strobe: got %0d strobes want 0", strobes); else n_pass++;
    endtask

    task automatic test_rd_zero();
        int cyc, cnt, busy, bad;
        logic [31:0] data;
        logic [4:0]  addr;
        issue(MUL_OP, 32'd7, 32'd6, 5'd0, -1, -1, 40, 1'b0, cyc, cnt, data, addr, busy, bad);
        n_total++; if (cnt !== 0) $display("FAIL rd0_strobe: got %0d strobes want 0", cnt); else n_pass++;
        n_total++; if (busy !== 33) $display("FAIL rd0_busy_window: got %0d want 33", busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc, cnt, busy, bad;
        logic [31:0] data, exp;
        logic [4:0]  addr;
        exp = ref_result(MULHU_OP, 32'hDEAD_BEEF, 32'h1234_5678);
        issue(MULHU_OP, 32'hDEAD_BEEF, 32'h1234_5678, 5'd11, -1, -1, 40, 1'b1, cyc, cnt, data, addr, busy, bad);
        n_total++; if (data !== exp) $display("FAIL b2b_first_data: got %h want %h", data, exp); else n_pass++;
        n_total++; if (mdu.ready !== 1'b1) $display("FAIL b2b_ready_at_strobe: got %b want 1", mdu.ready); else n_pass++;
        issue(REM_OP, 32'hFFFF_FF9C, 32'd7, 5'd12, -1, -1, 40, 1'b0, cyc, cnt, data, addr, busy, bad);
        n_total++; if (data !== 32'hFFFF_FFFE) $display("FAIL b2b_second_data: got %h want fffffffe", data); else n_pass++;
        n_total++; if (cyc !== 33) $display("FAIL b2b_second_latency: got %0d want 33", cyc); else n_pass++;
        n_total++; if (addr !== 5'd12) $display("FAIL b2b_second_addr: got %0d want 12", addr); else n_pass++;
    endtask

    task automatic test_reset_mid_calc();
        int strobes = 0;
        wait_ready();
        mdu.op = MUL_OP; mdu.rs1_data = 32'd3; mdu.rs2_data = 32'd5; mdu.rd_addr = 5'd9;
        mdu.start = 1'b1;
        @(posedge clk); #1;
        mdu.start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        n_total++; if (mdu.busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", mdu.busy); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if (mdu.ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", mdu.ready); else n_pass++;
        n_total++; if (mdu.busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", mdu.busy); else n_pass++;
        n_total++; if (mdu.reg_addr_write !== 5'd0) $display("FAIL rstmid_addr: got %0d want 0", mdu.reg_addr_write); else n_pass++;
        n_total++; if (mdu.reg_data_write !== 32'd0) $display("FAIL rstmid_data: got %h want 0", mdu.reg_data_write); else n_pass++;
        #2 rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (mdu.reg_enable_write) strobes++;
        end
        n_total++; if (strobes !== 0) $display("FAIL rstmid_strobe: got %0d strobes want 0", strobes); else n_pass++;
    endtask

    task automatic test_random();
        int cyc, cnt, busy, bad, lat;
        logic [31:0] a, b, data, exp;
        logic [4:0]  rd, addr;
        logic [2:0]  op;
        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = pick_operand();
            b   = pick_operand();
            rd  = 5'($urandom_range(1, 31));
            exp = ref_result(op, a, b);
            lat = ref_special(op, a, b) ? 1 : 33;
            issue(op, a, b, rd, -1, -1, 40, 1'b0, cyc, cnt, data, addr, busy, bad);
            n_total++;
            if (data !== exp) $display("FAIL rnd%0d_data op=%0d a=%h b=%h: got %h want %h", i, op, a, b, data, exp);
            else n_pass++;
            n_total++; if (cyc !== lat) $display("FAIL rnd%0d_latency: got %0d want %0d", i, cyc, lat); else n_pass++;
            n_total++; if (addr !== rd) $display("FAIL rnd%0d_addr: got %0d want %0d", i, addr, rd); else n_pass++;
            n_total++; if (cnt !== 1) $display("FAIL rnd%0d_strobe_count: got %0d want 1", i, cnt); else n_pass++;
        end
    endtask

    initial begin
        mdu.start = 1'b0; mdu.kill = 1'b0; mdu.op = '0;
        mdu.rs1_data = '0; mdu.rs2_data = '0; mdu.rd_addr = '0;
        test_reset();
        test_mul_basic();
        test_directed();
        test_kill();
        test_kill_start_idle();
        test_rd_zero();
        test_back_to_back();
        test_reset_mid_calc();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
